mac_seq: RTL and testbench
==========================

MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 SHALL have parameter ADD_LAT, default 3: float adder pipeline latency in cycles; legal range 1..15.
REQ-002 SHALL have parameter RED_STEPS, default 2: number of reduction passes (log2 of CELL_N for the standard array); legal range 0..7.
REQ-003 SHALL have parameter LEN_W, default 10: width of the input-count field.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-high (1 = reset) despite the name.
REQ-006 start  input  1  one-cycle request to run one neuron accumulation.
REQ-007 len  input  LEN_W  number of multiplier words to accumulate; sampled with start.
REQ-008 abort  input  1  synchronous cancel of the current run.
REQ-009 in_valid  input  1  multiplier output word is valid this cycle.
REQ-010 in_ready  output  1  controller accepts a multiplier word this cycle.
REQ-011 d_valid  output  1  multiplier data gate to the adder array; equals in_valid AND in_ready.
REQ-012 issue  output  1  adder array samples its inputs this cycle.
REQ-013 feed_zero  output  1  zero the accumulator feedback operand on this issue.
REQ-014 acc_mux  output  1  adder input select: 0 = accumulate, 1 = pairwise reduction.
REQ-015 acc_enable  output  1  load adder output into the MAC result register.
REQ-016 busy  output  1  run in progress.
REQ-017 done  output  1  one-cycle pulse; result is stable on mac_out.

Function
REQ-018 States SHALL be IDLE, ACC, AWAIT, CAP, RED, RWAIT, DONE. Input counter cnt is LEN_W bits, step counter is 3 bits, wait counter is 4 bits.
REQ-019 IDLE: start=1 with len!=0 SHALL latch len, clear cnt and step, and move to ACC. start with len=0 SHALL be ignored.
REQ-020 ACC: in_ready=1. When in_valid=1, SHALL assert issue=1 and d_valid=1, set feed_zero=1 only when cnt=0, and increment cnt. Go to AWAIT if ADD_LAT>1, otherwise go straight to the AWAIT exit decision. When in_valid=0, stay in ACC with all strobes at 0.
REQ-021 AWAIT: hold ADD_LAT-1 cycles with in_ready=0, issue=0, acc_mux=0. On exit, go to ACC if cnt<len, otherwise go to CAP.
REQ-022 CAP: acc_enable=1 for exactly one cycle. Go to RED if step<RED_STEPS, otherwise go to DONE.
REQ-023 RED: issue=1 and acc_mux=1 for one cycle, increment step, then go to RWAIT (ADD_LAT>1) or CAP (ADD_LAT=1).
REQ-024 RWAIT: hold ADD_LAT-1 cycles with acc_mux=1 and issue=0, then go to CAP.
REQ-025 DONE: done=1 for one cycle, then go to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE. start while busy SHALL be ignored.
REQ-027 With no in_valid stalls, done SHALL assert N*L + S*(L+1) + 2 cycles after the start cycle (N=len, L=ADD_LAT, S=RED_STEPS).
REQ-028 acc_mux SHALL be 0 in IDLE, ACC, AWAIT, CAP and DONE.
REQ-029 issue, feed_zero, d_valid, in_ready, acc_enable and done SHALL be 0 in every state not listed above as asserting them.
REQ-030 abort=1 in any state SHALL force IDLE on the next edge with no done and no acc_enable. abort takes priority over all transitions; abort and start in the same IDLE cycle: abort wins.
REQ-031 in_valid during a stall SHALL not be lost: the word is consumed only on the in_valid AND in_ready cycle.
REQ-032 len equal to 2^LEN_W-1 SHALL be supported without cnt wrap.

Reset
REQ-033 rst_n=1 at a clock edge SHALL force IDLE and clear cnt, step and wait counter. All outputs SHALL be 0 on the following cycle, including when reset arrives mid-run.
REQ-034 After reset release, the first start SHALL behave exactly as a run from power-up.

Verification
REQ-035 L=3, S=2, start len=4, in_valid held 1 -> issue at cycles 1,4,7,10,14,18; acc_enable at 13,17,21; done at 22; feed_zero only at 1.
REQ-036 Same config, in_valid low cycles 4-6 -> second ACC issue moves to cycle 7, done at 25, d_valid never high while in_ready=0.
REQ-037 L=1, S=0, len=1 -> issue at 1, acc_enable at 2, done at 3; acc_mux never 1.
REQ-038 start with len=0, then start during busy -> first ignored (busy stays 0), second ignored with no restart of counters.
REQ-039 abort at cycle 15 of the REQ-035 run -> busy=0 at 16, no done; new start at 20 -> done at 20+22.
REQ-040 reset asserted at cycle 9 of the REQ-035 run -> all outputs 0 from cycle 10, state IDLE.

Source files
------------

// File: rtl/mac_seq.sv
// Sequencer for one neuron's multiply-accumulate: accumulates len multiplier
// words through a pipelined float adder, then runs pairwise reduction passes.
module mac_seq #(
  parameter int ADD_LAT   = 3,
  parameter int RED_STEPS = 2,
  parameter int LEN_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d_valid,
  output logic             issue,
  output logic             feed_zero,
  output logic             acc_mux,
  output logic             acc_enable,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE, ACC, AWAIT, CAP, RED, RWAIT, DONE
  } state_t;

  // Last value of the wait counter before leaving AWAIT/RWAIT (ADD_LAT-1 cycles).
  localparam logic [3:0] WAIT_LAST = 4'((ADD_LAT > 1) ? (ADD_LAT - 2) : 0);
  localparam logic [3:0] RED_LIM   = 4'(RED_STEPS);
  localparam bit         HAS_WAIT  = (ADD_LAT > 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       step_q, step_d;
  logic [3:0]       wait_q, wait_d;
  logic [LEN_W:0]   cnt_inc;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      step_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
    end
  end

  // One extra bit so a len of all-ones never wraps the comparison.
  assign cnt_inc = {1'b0, cnt_q} + (LEN_W+1)'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    step_d     = step_q;
    wait_d     = wait_q;
    in_ready   = 1'b0;
    issue      = 1'b0;
    feed_zero  = 1'b0;
    acc_mux    = 1'b0;
    acc_enable = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          len_d   = len;
          cnt_d   = '0;
          step_d  = '0;
          wait_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          issue     = 1'b1;
          feed_zero = (cnt_q == '0);
          cnt_d     = cnt_inc[LEN_W-1:0];
          wait_d    = '0;
          if (HAS_WAIT) begin
            state_d = AWAIT;
          end else begin
            state_d = (cnt_inc < {1'b0, len_q}) ? ACC : CAP;
          end
        end
      end
      AWAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = (cnt_q < len_q) ? ACC : CAP;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      CAP: begin
        acc_enable = 1'b1;
        state_d    = ({1'b0, step_q} < RED_LIM) ? RED : DONE;
      end
      RED: begin
        issue   = 1'b1;
        acc_mux = 1'b1;
        step_d  = step_q + 3'd1;
        wait_d  = '0;
        state_d = HAS_WAIT ? RWAIT : CAP;
      end
      RWAIT: begin
        acc_mux = 1'b1;
        if (wait_q == WAIT_LAST) begin
          state_d = CAP;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An aborted run must not publish a partial result.
    if (abort) begin
      state_d    = IDLE;
      acc_enable = 1'b0;
      done       = 1'b0;
    end
  end

  assign busy    = (state_q != IDLE);
  assign d_valid = in_valid & in_ready;

endmodule

// File: tb/tb_mac_seq.sv
// Randomized bench for mac_seq: two instances (L=3,S=2 and L=1,S=0) checked
// cycle by cycle against an event-time model of the accumulate/reduce schedule.
module tb_mac_seq;

  localparam int LEN_W = 10;
  localparam int MAXC  = 4096;
  localparam int B_RDY = 0, B_DV = 1, B_ISS = 2, B_FZ = 3;
  localparam int B_MUX = 4, B_AEN = 5, B_DONE = 6, B_BUSY = 7;

  logic             clk = 1'b0;
  logic             rst_s[2];
  logic             start_s[2];
  logic [LEN_W-1:0] len_s[2];
  logic             abort_s[2];
  logic             iv_s[2];
  logic [7:0]       out_v[2];

  int n_cmp = 0;
  int n_bad = 0;
  int run_id = 0;
  bit iv_g[MAXC];

  always #5 clk = ~clk;

  mac_seq #(.ADD_LAT(3), .RED_STEPS(2), .LEN_W(LEN_W)) dut0 (
    .clk(clk), .rst_n(rst_s[0]), .start(start_s[0]), .len(len_s[0]),
    .abort(abort_s[0]), .in_valid(iv_s[0]),
    .in_ready(out_v[0][B_RDY]), .d_valid(out_v[0][B_DV]), .issue(out_v[0][B_ISS]),
    .feed_zero(out_v[0][B_FZ]), .acc_mux(out_v[0][B_MUX]), .acc_enable(out_v[0][B_AEN]),
    .busy(out_v[0][B_BUSY]), .done(out_v[0][B_DONE])
  );

  mac_seq #(.ADD_LAT(1), .RED_STEPS(0), .LEN_W(LEN_W)) dut1 (
    .clk(clk), .rst_n(rst_s[1]), .start(start_s[1]), .len(len_s[1]),
    .abort(abort_s[1]), .in_valid(iv_s[1]),
    .in_ready(out_v[1][B_RDY]), .d_valid(out_v[1][B_DV]), .issue(out_v[1][B_ISS]),
    .feed_zero(out_v[1][B_FZ]), .acc_mux(out_v[1][B_MUX]), .acc_enable(out_v[1][B_AEN]),
    .busy(out_v[1][B_BUSY]), .done(out_v[1][B_DONE])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_iv(input int stall_pct);
    for (int c = 0; c < MAXC; c++) iv_g[c] = ($urandom_range(99) >= stall_pct);
  endtask

  task automatic idle_inputs();
    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b0; start_s[s] = 1'b0; len_s[s] = '0;
      abort_s[s] = 1'b0; iv_s[s] = 1'b0;
    end
  endtask

  // kill_at: -1 none, -2 random cycle inside the run, else that cycle.
  // as_reset: the kill uses rst_n instead of abort.
  task automatic run(input int sel, input int n, input int kill_at, input bit as_reset,
                     input bit spurious, output int done_at);
    int L, S, ready, c, last, dn, cap, end_c, a;
    logic [7:0] ex[MAXC];
    bit sp[MAXC];
    logic [LEN_W-1:0] sp_len[MAXC];
    L = (sel == 0) ? 3 : 1;
    S = (sel == 0) ? 2 : 0;
    run_id++;
    done_at = -1;
    for (int i = 0; i < MAXC; i++) begin ex[i] = '0; sp[i] = 1'b0; sp_len[i] = '0; end

    // Schedule: each word issues at the first valid cycle once the adder frees up.
    dn = 0;
    if (n != 0) begin
      ready = 1;
      last = 1;
      for (int k = 0; k < n; k++) begin
        c = ready;
        while (c < MAXC - 64 && !iv_g[c]) c++;
        for (int t = ready; t <= c; t++) ex[t][B_RDY] = 1'b1;
        ex[c][B_ISS] = 1'b1;
        ex[c][B_DV]  = 1'b1;
        if (k == 0) ex[c][B_FZ] = 1'b1;
        ready = c + L;
        last = c;
      end
      for (int j = 0; j <= S; j++) begin
        cap = last + L + j * (L + 1);
        ex[cap][B_AEN] = 1'b1;
        if (j < S) begin
          ex[cap+1][B_ISS] = 1'b1;
          for (int t = cap + 1; t <= cap + L; t++) ex[t][B_MUX] = 1'b1;
        end
      end
      dn = last + L + S * (L + 1) + 1;
      ex[dn][B_DONE] = 1'b1;
      for (int t = 1; t <= dn; t++) ex[t][B_BUSY] = 1'b1;
      end_c = dn + 3;
    end else begin
      end_c = 6;
    end

    a = kill_at;
    if (a == -2) a = (n != 0) ? $urandom_range(dn, 1) : 0;
    if (a >= 0) begin
      ex[a][B_DONE] = 1'b0;
      if (!as_reset) ex[a][B_AEN] = 1'b0;
      for (int t = a + 1; t < MAXC; t++) ex[t] = '0;
      end_c = a + 5;
    end

    if (spurious && n != 0) begin
      for (int t = 1; t < dn; t++) begin
        if ((a < 0 || t < a) && $urandom_range(99) < 25) begin
          sp[t] = 1'b1;
          sp_len[t] = LEN_W'($urandom_range(20, 1));
        end
      end
    end

    for (int cy = 0; cy <= end_c; cy++) begin
      @(negedge clk);
      idle_inputs();
      start_s[sel] = (cy == 0) || sp[cy];
      len_s[sel]   = (cy == 0) ? LEN_W'(n) : sp_len[cy];
      iv_s[sel]    = iv_g[cy];
      if (cy == a) begin
        if (as_reset) rst_s[sel] = 1'b1;
        else abort_s[sel] = 1'b1;
      end
      #1;
      if (!(as_reset && cy == a))
        check($sformatf("run%0d dut%0d cyc%0d outs", run_id, sel, cy), 32'(out_v[sel]), 32'(ex[cy]));
      if (out_v[sel][B_DONE] === 1'b1 && done_at < 0) done_at = cy;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    int d;
    idle_inputs();
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    start_s[0] = 1'b1; start_s[1] = 1'b1; len_s[0] = 10'd5; len_s[1] = 10'd5;
    repeat (2) @(negedge clk);
    idle_inputs();
    #1;
    check("reset dut0", 32'(out_v[0]), 32'd0);
    check("reset dut1", 32'(out_v[1]), 32'd0);

    for (int c = 0; c < MAXC; c++) iv_g[c] = 1'b1;
    run(0, 4, -1, 1'b0, 1'b0, d);  check("basic done cycle", d, 22);
    iv_g[4] = 1'b0; iv_g[5] = 1'b0; iv_g[6] = 1'b0;
    run(0, 4, -1, 1'b0, 1'b0, d);  check("stall done cycle", d, 25);
    for (int c = 0; c < MAXC; c++) iv_g[c] = 1'b1;
    run(1, 1, -1, 1'b0, 1'b0, d);  check("lat1 done cycle", d, 3);
    run(0, 0, -1, 1'b0, 1'b0, d);  check("len0 no done", d, -1);
    run(0, 4, -1, 1'b0, 1'b1, d);  check("busy start ignored", d, 22);
    run(0, 4, 15, 1'b0, 1'b0, d);  check("abort no done", d, -1);
    run(0, 4, -1, 1'b0, 1'b0, d);  check("post-abort done", d, 22);
    run(0, 4, 9, 1'b1, 1'b0, d);   check("reset no done", d, -1);
    run(0, 4, -1, 1'b0, 1'b0, d);  check("post-reset done", d, 22);
    run(0, 3, 0, 1'b0, 1'b0, d);   check("abort beats start", d, -1);
    run(1, 1023, -1, 1'b0, 1'b0, d); check("max len done", d, 1025);

    for (int r = 0; r < 40; r++) begin
      int sel, n, kill, mode;
      sel = $urandom_range(1);
      n = $urandom_range(12, 1);
      mode = $urandom_range(99);
      kill = (mode < 30) ? -2 : -1;
      fill_iv(30);
      run(sel, n, kill, (mode < 15), $urandom_range(1), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
